// File: rtl/uart_rx_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cmd_parser
// Brief   : Assembles UART receiver bytes into WR/RD/ALU command frames and
//           presents them on a valid/ready bus, with a separate error pulse.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_cmd_parser #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_par_err,
  input  logic              rx_frm_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_wdata,
  output logic [7:0]        cmd_op_a,
  output logic [7:0]        cmd_op_b,
  output logic [3:0]        cmd_fun,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] C_TYPE_WR      = 2'd0;
  localparam logic [1:0] C_TYPE_RD      = 2'd1;
  localparam logic [1:0] C_TYPE_ALU_OP  = 2'd2;
  localparam logic [1:0] C_TYPE_ALU_NOP = 2'd3;

  localparam logic [1:0] C_ERR_BAD_BYTE = 2'd0;
  localparam logic [1:0] C_ERR_UNKNOWN  = 2'd1;
  localparam logic [1:0] C_ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] C_ERR_OVERRUN  = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_WDATA = 3'd2,
    GET_OPA   = 3'd3,
    GET_OPB   = 3'd4,
    GET_FUN   = 3'd5,
    ISSUE     = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          opa_q, opa_d;
  logic [7:0]          opb_q, opb_d;
  logic [3:0]          fun_q, fun_d;
  logic                err_valid_q, err_valid_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                w_bad_byte;

  assign w_bad_byte = rx_par_err | rx_frm_err;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    fun_d       = fun_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    cnt_d       = '0;

    if (state_q == ISSUE) begin
      // Bytes arriving while a command is pending are dropped; flags ignored.
      if (rx_valid) begin
        err_valid_d = 1'b1;
        err_code_d  = C_ERR_OVERRUN;
      end
      if (cmd_ready) state_d = IDLE;
    end else if (rx_valid) begin
      if (w_bad_byte) begin
        state_d     = IDLE;
        err_valid_d = 1'b1;
        err_code_d  = C_ERR_BAD_BYTE;
      end else begin
        case (state_q)
          IDLE: begin
            case (rx_data)
              8'hAA: begin type_d = C_TYPE_WR;      state_d = GET_ADDR; end
              8'hBB: begin type_d = C_TYPE_RD;      state_d = GET_ADDR; end
              8'hCC: begin type_d = C_TYPE_ALU_OP;  state_d = GET_OPA;  end
              8'hDD: begin type_d = C_TYPE_ALU_NOP; state_d = GET_FUN;  end
              default: begin
                err_valid_d = 1'b1;
                err_code_d  = C_ERR_UNKNOWN;
              end
            endcase
          end
          GET_ADDR: begin
            addr_d  = rx_data[ADDR_W-1:0];
            state_d = (type_q == C_TYPE_WR) ? GET_WDATA : ISSUE;
          end
          GET_WDATA: begin
            wdata_d = rx_data;
            state_d = ISSUE;
          end
          GET_OPA: begin
            opa_d   = rx_data;
            state_d = GET_OPB;
          end
          GET_OPB: begin
            opb_d   = rx_data;
            state_d = GET_FUN;
          end
          GET_FUN: begin
            fun_d   = rx_data[3:0];
            state_d = ISSUE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      // Inside a frame with no byte this cycle: run the inter-byte watchdog.
      if (cnt_q == C_CNT_LAST) begin
        state_d     = IDLE;
        err_valid_d = 1'b1;
        err_code_d  = C_ERR_TIMEOUT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      type_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      fun_q       <= fun_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_type  = type_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;
  assign cmd_op_a  = opa_q;
  assign cmd_op_b  = opb_q;
  assign cmd_fun   = fun_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_cmd_parser
// Brief   : Directed self-checking bench for uart_rx_cmd_parser (TIMEOUT=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd_parser;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_par_err = 1'b0;
  logic              rx_frm_err = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic [7:0]        cmd_op_a;
  logic [7:0]        cmd_op_b;
  logic [3:0]        cmd_fun;
  logic              err_valid;
  logic [1:0]        err_code;

  int checks = 0;
  int errors = 0;

  uart_rx_cmd_parser #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_par_err (rx_par_err),
    .rx_frm_err (rx_frm_err),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_op_a   (cmd_op_a),
    .cmd_op_b   (cmd_op_b),
    .cmd_fun    (cmd_fun),
    .err_valid  (err_valid),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic par, input logic frm);
    rx_data    = b;
    rx_valid   = 1'b1;
    rx_par_err = par;
    rx_frm_err = frm;
    tick();
    rx_valid   = 1'b0;
    rx_par_err = 1'b0;
    rx_frm_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun, err_valid, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b type=%0d addr=%h wdata=%h opa=%h opb=%h fun=%h errv=%b code=%0d expected all 0",
               cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun, err_valid, err_code);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    cmd_ready = 1'b1;
    send(8'hAA, 0, 0);
    send(8'h13, 0, 0);
    send(8'h5C, 0, 0);
    checks++;
    if ({cmd_valid, cmd_type, cmd_addr, cmd_wdata, err_valid} !== {1'b1, 2'd0, 4'h3, 8'h5C, 1'b0}) begin
      errors++;
      $display("FAIL write_cmd: valid=%b type=%0d addr=%h wdata=%h errv=%b expected 1/0/3/5c/0",
               cmd_valid, cmd_type, cmd_addr, cmd_wdata, err_valid);
    end
    tick();
    checks++;
    if ({cmd_valid, err_valid} !== 2'b00) begin
      errors++;
      $display("FAIL write_accept: valid=%b errv=%b expected 0/0", cmd_valid, err_valid);
    end
  endtask

  task automatic test_alu_hold();
    int held_bad = 0;
    cmd_ready = 1'b0;
    send(8'hCC, 0, 0);
    send(8'h07, 0, 0);
    send(8'h09, 0, 0);
    send(8'hF2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if ({cmd_valid, cmd_type, cmd_op_a, cmd_op_b, cmd_fun} !== {1'b1, 2'd2, 8'h07, 8'h09, 4'h2})
        held_bad++;
      if (i < 9) tick();
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL alu_hold: %0d of 10 cycles wrong (last valid=%b type=%0d a=%h b=%h fun=%h) expected 1/2/07/09/2",
               held_bad, cmd_valid, cmd_type, cmd_op_a, cmd_op_b, cmd_fun);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_accept: valid=%b expected 0", cmd_valid);
    end
    send(8'hBB, 0, 0);
    send(8'h0A, 0, 0);
    checks++;
    if ({cmd_valid, cmd_type, cmd_addr} !== {1'b1, 2'd1, 4'hA}) begin
      errors++;
      $display("FAIL read_cmd: valid=%b type=%0d addr=%h expected 1/1/a", cmd_valid, cmd_type, cmd_addr);
    end
    tick();
  endtask

  task automatic test_unknown();
    cmd_ready = 1'b1;
    send(8'h55, 0, 0);
    checks++;
    if ({err_valid, err_code, cmd_valid} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL unknown_err: errv=%b code=%0d valid=%b expected 1/1/0", err_valid, err_code, cmd_valid);
    end
    tick();
    checks++;
    if ({err_valid, err_code} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL unknown_pulse: errv=%b code=%0d expected 0/1 (one-cycle pulse, code held)", err_valid, err_code);
    end
    send(8'hDD, 0, 0);
    send(8'h04, 0, 0);
    checks++;
    if ({cmd_valid, cmd_type, cmd_fun} !== {1'b1, 2'd3, 4'h4}) begin
      errors++;
      $display("FAIL nop_cmd: valid=%b type=%0d fun=%h expected 1/3/4", cmd_valid, cmd_type, cmd_fun);
    end
    tick();
  endtask

  task automatic test_bad_byte();
    cmd_ready = 1'b1;
    send(8'hAA, 0, 0);
    send(8'h02, 0, 0);
    send(8'h77, 1, 0);
    checks++;
    if ({err_valid, err_code, cmd_valid} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL parity_abort: errv=%b code=%0d valid=%b expected 1/0/0", err_valid, err_code, cmd_valid);
    end
    send(8'hAA, 1, 1);
    checks++;
    if ({err_valid, err_code, cmd_valid} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL both_flags: errv=%b code=%0d valid=%b expected 1/0/0", err_valid, err_code, cmd_valid);
    end
    tick();
    checks++;
    if (err_valid !== 1'b0) begin
      errors++;
      $display("FAIL both_flags_single: errv=%b expected 0", err_valid);
    end
    send(8'hBB, 0, 0);
    send(8'h01, 0, 0);
    checks++;
    if ({cmd_valid, cmd_type, cmd_addr, err_valid} !== {1'b1, 2'd1, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL resync_read: valid=%b type=%0d addr=%h errv=%b expected 1/1/1/0",
               cmd_valid, cmd_type, cmd_addr, err_valid);
    end
    tick();
  endtask

  task automatic test_timeout();
    int early = 0;
    send(8'hCC, 0, 0);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (err_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: err pulses before edge %0d = %0d expected 0", TIMEOUT, early);
    end
    tick();
    checks++;
    if ({err_valid, err_code, cmd_valid} !== {1'b1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL timeout_fire: errv=%b code=%0d valid=%b expected 1/2/0", err_valid, err_code, cmd_valid);
    end
    // Second frame: a byte on the 15th idle edge restarts the watchdog.
    send(8'hCC, 0, 0);
    early = 0;
    for (int i = 1; i < TIMEOUT - 1; i++) begin
      tick();
      if (err_valid !== 1'b0) early++;
    end
    send(8'h11, 0, 0);
    if (err_valid !== 1'b0) early++;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (err_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_restart: unexpected err pulses = %0d expected 0", early);
    end
    tick();
    checks++;
    if ({err_valid, err_code} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL timeout_restart_fire: errv=%b code=%0d expected 1/2", err_valid, err_code);
    end
    cmd_ready = 1'b1;
    send(8'hDD, 0, 0);
    send(8'h05, 0, 0);
    checks++;
    if ({cmd_valid, cmd_type, cmd_fun, cmd_op_a} !== {1'b1, 2'd3, 4'h5, 8'h11}) begin
      errors++;
      $display("FAIL after_timeout: valid=%b type=%0d fun=%h opa=%h expected 1/3/5/11",
               cmd_valid, cmd_type, cmd_fun, cmd_op_a);
    end
    tick();
  endtask

  task automatic test_overrun();
    cmd_ready = 1'b0;
    send(8'hDD, 0, 0);
    send(8'h06, 0, 0);
    send(8'hAA, 1, 0);
    checks++;
    if ({err_valid, err_code, cmd_valid, cmd_type, cmd_fun} !== {1'b1, 2'd3, 1'b1, 2'd3, 4'h6}) begin
      errors++;
      $display("FAIL overrun: errv=%b code=%0d valid=%b type=%0d fun=%h expected 1/3/1/3/6",
               err_valid, err_code, cmd_valid, cmd_type, cmd_fun);
    end
    cmd_ready = 1'b1;
    send(8'hBB, 0, 0);
    checks++;
    if ({err_valid, err_code, cmd_valid, cmd_type} !== {1'b1, 2'd3, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL overrun_accept: errv=%b code=%0d valid=%b type=%0d expected 1/3/0/3",
               err_valid, err_code, cmd_valid, cmd_type);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b1;
    send(8'hCC, 0, 0);
    send(8'h01, 0, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun, err_valid, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b type=%0d addr=%h wdata=%h opa=%h fun=%h errv=%b code=%0d expected all 0",
               cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_fun, err_valid, err_code);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (err_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_noerr: errv=%b expected 0", err_valid);
    end
    send(8'hDD, 0, 0);
    send(8'h03, 0, 0);
    checks++;
    if ({cmd_valid, cmd_type, cmd_fun, cmd_op_a} !== {1'b1, 2'd3, 4'h3, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_decode: valid=%b type=%0d fun=%h opa=%h expected 1/3/3/00",
               cmd_valid, cmd_type, cmd_fun, cmd_op_a);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_alu_hold();
    test_unknown();
    test_bad_byte();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cmd_parser.md
Name: uart_rx_cmd_parser

Overview:
- Downstream consumer of the UART receiver.
- Takes the receiver's byte stream (parallel data, data-valid pulse, parity/framing error flags) and assembles multi-byte command frames.
- Frames: register write, register read, ALU op with operands, ALU op without operands.
- Presents each decoded command on a held valid/ready bus to the system controller; reports malformed, unknown, stalled and overrun frames on a separate error pulse.

Parameters:
ADDR_W, 4, width of register address field taken from the address byte (LSBs).
TIMEOUT, 4096, idle clock cycles allowed between bytes inside a frame before abort (>=2).

Ports:
clk  input  1  system clock (all logic on rising edge)
rst  input  1  reset, asynchronous, active-high
rx_data  input  8  received byte, valid when rx_valid=1
rx_valid  input  1  one-cycle pulse per received byte
rx_par_err  input  1  parity error for the byte; sampled only when rx_valid=1
rx_frm_err  input  1  framing error for the byte; sampled only when rx_valid=1
cmd_valid  output  1  command available; held until accepted
cmd_ready  input  1  controller accepts command when cmd_valid&cmd_ready at clock edge
cmd_type  output  2  0=WR, 1=RD, 2=ALU_OP, 3=ALU_NOP
cmd_addr  output  ADDR_W  register address (WR/RD)
cmd_wdata  output  8  write data (WR)
cmd_op_a  output  8  ALU operand A (ALU_OP)
cmd_op_b  output  8  ALU operand B (ALU_OP)
cmd_fun  output  4  ALU function (ALU_OP/ALU_NOP)
err_valid  output  1  one-cycle error pulse
err_code  output  2  0=bad byte (parity/framing), 1=unknown command, 2=timeout, 3=overrun

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-frame discards the frame immediately, with no error pulse.
- Frames (first byte = command):
  - 0xAA WR: addr, wdata.
  - 0xBB RD: addr.
  - 0xCC ALU_OP: op_a, op_b, fun.
  - 0xDD ALU_NOP: fun.
- Field extraction: addr = rx_data[ADDR_W-1:0]; fun = rx_data[3:0]; upper bits ignored.
- States: IDLE, GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN, ISSUE.
- IDLE:
  - On good byte 0xAA/0xBB -> GET_ADDR; 0xCC -> GET_OPA; 0xDD -> GET_FUN.
  - Latch cmd_type in the same edge.
  - Any other good byte -> stay IDLE, err pulse code 1.
- GET_ADDR: latch addr; WR -> GET_WDATA, RD -> ISSUE.
- GET_WDATA -> ISSUE.
- GET_OPA -> GET_OPB -> GET_FUN -> ISSUE.
- Bad byte: rx_valid with rx_par_err or rx_frm_err, in IDLE or any GET_* state.
  - Byte discarded, frame aborted, next state IDLE, err pulse code 0.
  - Both flags set: single pulse, code 0.
- ISSUE:
  - cmd_valid=1 starting the cycle after the final byte's rx_valid edge (one-cycle latency).
  - All cmd_* fields stable while cmd_valid=1.
  - On edge with cmd_ready=1: cmd_valid->0, state->IDLE.
  - cmd_ready while cmd_valid=0 is ignored.
- Overrun: any rx_valid while in ISSUE, including the accept cycle, drops the byte and pulses err code 3. State and cmd fields are unaffected; the error flags of that byte are ignored.
- Field persistence: cmd_* data fields keep last latched values after accept; only cmd_valid qualifies them. Fields not used by a command type retain stale values.
- Timeout counter (width clog2(TIMEOUT)+1):
  - Cleared in IDLE, ISSUE and on every rx_valid.
  - Increments each cycle in GET_* states without rx_valid.
  - Abort: in a GET_* state with counter == TIMEOUT-1 and no rx_valid, next state IDLE and err pulse code 2. The abort takes effect at the TIMEOUT-th consecutive idle edge.
- err_valid/err_code are registered; err_valid is high exactly one cycle per event; err_code holds its last value otherwise.
- Simultaneous events: only one error source is possible per cycle, because timeout requires no rx_valid.
- Throughput: back-to-back rx_valid (every cycle) is supported in IDLE/GET_* states.

Test Plan:
- Reset, then bytes 0xAA,0x13,0x5C, cmd_ready=1 -> one cycle after 3rd byte cmd_valid=1, type=0, addr=0x3, wdata=0x5C; next cycle cmd_valid=0, no err.
- 0xCC,0x07,0x09,0xF2 with cmd_ready=0 for 10 cycles then 1 -> type=2, op_a=0x07, op_b=0x09, fun=0x2 held all 10 cycles, accept then IDLE; then 0xBB,0x0A accepted -> type=1, addr=0xA.
- Byte 0x55 in IDLE -> err_valid one cycle, code 1; following 0xDD,0x04 -> type=3, fun=0x4.
- 0xAA,0x02 then third byte with rx_par_err=1 -> err code 0, no cmd_valid; next 0xBB,0x01 decodes normally (frame resync).
- TIMEOUT=16: 0xCC then no bytes -> err code 2 exactly 16 cycles after 0xCC edge, state IDLE; variant with a byte at cycle 15 -> no timeout, counter restarts.
- In ISSUE with cmd_ready=0, inject 0xAA -> err code 3, cmd fields unchanged; assert rst mid-frame (after 0xCC,0x01) -> all outputs 0 immediately, no err pulse, next 0xDD,0x03 decodes.
